fpa_byte_io: RTL and testbench
==============================

# fpa_byte_io

Byte-serial operand loader and result unloader for the FP32 adder (`FPA`). The chip's pins are limited, so operands arrive one byte at a time. This block assembles the 32-bit A and B operands and drives them into the adder. It then captures `Sum`, `Cout` and `of`, and returns the result as five output bytes over a valid/ready channel. The block sits directly between the pad-side byte bus and `FPA`, and is instantiated next to it in the chip top.

## Interface
- `LSB_FIRST`, default 1. 1: byte 0 of each word is bits [7:0]. 0: byte 0 is bits [31:24].
- `clk` in 1. Single clock; all state updates on the rising edge.
- `rst` in 1. Synchronous, active-high reset.
- `in_data` in 8. Operand byte.
- `in_valid` in 1. `in_data` is valid.
- `in_ready` out 1. Block accepts a byte this cycle.
- `out_data` out 8. Result or status byte.
- `out_valid` out 1. `out_data` is valid.
- `out_ready` in 1. Consumer accepts the byte this cycle.
- `fpa_a` out 32. Operand A register, drives `FPA.A`.
- `fpa_b` out 32. Operand B register, drives `FPA.B`.
- `fpa_sum` in 32. From `FPA.Sum`.
- `fpa_cout` in 1. From `FPA.Cout`.
- `fpa_of` in 1. From `FPA.of`.
- `busy` out 1. High in CALC and SEND.

## Operation
- **Transfers.** An input transfer happens when `in_valid && in_ready`. An output transfer happens when `out_valid && out_ready`.
- **States.** The FSM has four states: LOAD_A, LOAD_B, CALC, SEND. A 3-bit byte counter `cnt` tracks position within each state.
- **LOAD_A.** `in_ready`=1. Each transfer shifts the byte into `fpa_a`:
  - LSB_FIRST=1: `{in_data, a[31:8]}`.
  - LSB_FIRST=0: `{a[23:0], in_data}`.
  - `cnt` increments per transfer. On the 4th transfer, `cnt`←0 and the FSM moves to LOAD_B.
- **LOAD_B.** Same as LOAD_A, but loads `fpa_b`. On the 4th transfer the FSM moves to CALC.
- **CALC.** One cycle with `in_ready`=0. At the end of this cycle the block registers:
  - `res` ← `fpa_sum`
  - `flg` ← {`fpa_of`, `fpa_cout`}
  - The FSM then moves to SEND with `cnt`=0.
- **SEND.** `out_valid`=1. `out_data` is:
  - result byte `cnt` of `res` for `cnt` 0..3, in the same byte order as the inputs;
  - for `cnt`=4, the status byte `{6'b0, flg[1]=of, flg[0]=cout}`.
  - Each output transfer increments `cnt`. The 5th transfer returns the FSM to LOAD_A with `cnt`=0.
- **Stalls.** `out_data` and `out_valid` stay stable while `out_valid && !out_ready`. There is no timeout.
- **Ignored inputs.** `in_valid` is ignored outside the LOAD states. `out_ready` is ignored outside SEND.
- **Partial operands.** `fpa_a` and `fpa_b` show partially shifted values during loading. The adder output is sampled only in CALC.
- **Register hold.** `fpa_a` and `fpa_b` keep their last values through SEND. They are overwritten byte by byte in the next LOAD_A/LOAD_B.
- **Reset mid-operation.** Any partially loaded operand or unsent result is discarded, with no output transfer. The next cycle behaves as post-reset.

## Timing
- **Reset values** (while `rst`=1 and on the first cycle after):
  - state=LOAD_A, `cnt`=0;
  - `fpa_a`=`fpa_b`=0, `res`=0, `flg`=0;
  - `out_valid`=0, `out_data`=0, `busy`=0.
- **`in_ready` around reset.** `in_ready` is forced to 0 while `rst`=1. It is 1 on the first cycle after `rst` deasserts.
- **Output decode.** `in_ready`, `out_valid` and `busy` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- **Latency.** If the 8th input byte is accepted at edge N, CALC occupies cycle N→N+1 and `out_valid` rises after edge N+1.
- **Back-to-back.** After the 5th output transfer at edge M, `in_ready`=1 in cycle M→M+1.
- **Throughput.** The minimum cycle count per operation is 8 (load) + 1 (CALC) + 5 (send) = 14 cycles.
- **Adder timing.** `FPA` is combinational. Its path from the `fpa_a`/`fpa_b` registers to the `res` register must close in one `clk` period.

## Structure
- **Package `fpa_io_pkg`** holds:
  - the state enum (LOAD_A, LOAD_B, CALC, SEND);
  - `BYTES_PER_WORD`=4 and `OUT_BYTES`=5;
  - status bit positions `ST_COUT`=0 and `ST_OF`=1.
- **Sub-modules.** None. The block does not instantiate `FPA`; the chip top connects the two. The byte shift is a few lines per operand and does not warrant a module.

## Test plan
- **Basic add.** With real `FPA` attached, LSB_FIRST=1, no stalls:
  - send 00 00 80 3F, 00 00 80 3F (1.0 + 1.0);
  - required: out bytes 00 00 00 40, then status 01 (`cout`=1);
  - `out_valid` first high 2 edges after the 8th byte.
- **MSB-first order.** LSB_FIRST=0, send 40 40 00 00, BF 80 00 00 (3.0 + −1.0):
  - required: `fpa_a`=0x40400000 and `fpa_b`=0xBF800000 in CALC;
  - out bytes 40 00 00 00, then status byte 00.
- **Status flags.** Use an `FPA` stub that returns `fpa_sum`=0x7F800000, `fpa_of`=1, `fpa_cout`=0. Required: status byte 02.
- **Output stall.** Hold `out_ready`=0 for 10 cycles at byte 2:
  - required: `out_data` stays stable at result byte 2 and `out_valid` stays 1;
  - no byte is skipped or duplicated after release;
  - `in_valid`=1 throughout causes no input transfer.
- **Input gaps.** Randomly toggle `in_valid`. Required: `fpa_a`/`fpa_b` and the result match the gap-free run.
- **Reset mid-operation.**
  - `rst` after 5 input bytes → `in_ready`=1 next cycle. A fresh 8-byte operand pair gives the correct result, with no leftover bytes from before reset.
  - `rst` during SEND → `out_valid`=0 next cycle.

Source files
------------

// File: rtl/fpa_io_pkg.sv
// Shared types and constants for the byte-serial FP32 adder front end.
package fpa_io_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SEND   = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int OUT_BYTES      = 5;

  localparam int ST_COUT = 0;
  localparam int ST_OF   = 1;

endpackage

// File: rtl/fpa_byte_io.sv
// Byte-serial operand loader and result unloader sitting between the pad byte
// bus and the combinational FP32 adder.
//
// state  | meaning
// LOAD_A | shifting operand A in, one byte per input transfer
// LOAD_B | shifting operand B in, one byte per input transfer
// CALC   | single cycle, adder output captured into res/flg
// SEND   | four result bytes then one status byte on the output channel
module fpa_byte_io
  import fpa_io_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fpa_a,
  output logic [31:0] fpa_b,
  input  logic [31:0] fpa_sum,
  input  logic        fpa_cout,
  input  logic        fpa_of,
  output logic        busy
);

  localparam logic [2:0] LAST_IN  = 3'(BYTES_PER_WORD - 1);
  localparam logic [2:0] LAST_OUT = 3'(OUT_BYTES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] res;
  logic [1:0]  flg;
  logic        in_xfer, out_xfer;
  logic [7:0]  res_byte;

  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return LSB_FIRST ? {b, word[31:8]} : {word[23:0], b};
  endfunction

  // Handshake outputs come from registered state only; rst gates in_ready so
  // nothing is accepted on the reset edge.
  assign in_ready  = ((state == LOAD_A) || (state == LOAD_B)) && !rst;
  assign out_valid = (state == SEND);
  assign busy      = (state == CALC) || (state == SEND);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      LOAD_A, LOAD_B: begin
        if (in_xfer) begin
          if (cnt == LAST_IN) begin
            cnt_nxt   = 3'd0;
            state_nxt = (state == LOAD_A) ? LOAD_B : CALC;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      CALC: begin
        state_nxt = SEND;
        cnt_nxt   = 3'd0;
      end
      SEND: begin
        if (out_xfer) begin
          if (cnt == LAST_OUT) begin
            state_nxt = LOAD_A;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = LOAD_A;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Result bytes leave in the same order operand bytes arrive.
  always_comb begin
    res_byte = LSB_FIRST ? res[{cnt[1:0], 3'b000} +: 8] : res[{~cnt[1:0], 3'b000} +: 8];
    out_data = (cnt == LAST_OUT) ? {6'b0, flg} : res_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
      cnt   <= 3'd0;
      fpa_a <= 32'h0;
      fpa_b <= 32'h0;
      res   <= 32'h0;
      flg   <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (in_xfer && (state == LOAD_A)) fpa_a <= shift_in(fpa_a, in_data);
      if (in_xfer && (state == LOAD_B)) fpa_b <= shift_in(fpa_b, in_data);
      if (state == CALC) begin
        res          <= fpa_sum;
        flg[ST_OF]   <= fpa_of;
        flg[ST_COUT] <= fpa_cout;
      end
    end
  end

endmodule

// File: tb/tb_fpa_byte_io.sv
// Bench for fpa_byte_io: an LSB-first and an MSB-first instance share the byte
// buses and run in lockstep, each attached to its own adder stub.
module tb_fpa_byte_io;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  bit         ovf_mode  = 1'b0;

  logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [7:0]  out_data0, out_data1;
  logic [31:0] fpa_a0, fpa_b0, fpa_a1, fpa_b1, fpa_sum0, fpa_sum1;
  logic        fpa_cout0, fpa_of0, fpa_cout1, fpa_of1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [31:0] exp_a0, exp_b0, exp_a1, exp_b1;

  // Adder stand-in, returns {of, cout, sum}. Real values for the two planned
  // vectors, a forced overflow, otherwise an operand-dependent scramble.
  function automatic logic [33:0] fpa_stub(input logic [31:0] a, input logic [31:0] b, input bit ovf);
    if (ovf) return {1'b1, 1'b0, 32'h7F80_0000};
    if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return {1'b0, 1'b1, 32'h4000_0000};
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return {1'b0, 1'b0, 32'h4000_0000};
    return {b[31], a[0], a ^ {b[15:0], b[31:16]}};
  endfunction

  assign {fpa_of0, fpa_cout0, fpa_sum0} = fpa_stub(fpa_a0, fpa_b0, ovf_mode);
  assign {fpa_of1, fpa_cout1, fpa_sum1} = fpa_stub(fpa_a1, fpa_b1, ovf_mode);

  fpa_byte_io #(.LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .fpa_a(fpa_a0), .fpa_b(fpa_b0), .fpa_sum(fpa_sum0), .fpa_cout(fpa_cout0),
    .fpa_of(fpa_of0), .busy(busy0)
  );

  fpa_byte_io #(.LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .fpa_a(fpa_a1), .fpa_b(fpa_b1), .fpa_sum(fpa_sum1), .fpa_cout(fpa_cout1),
    .fpa_of(fpa_of1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   cyc;
    in_data  = b;
    in_valid = 1'b1;
    cyc      = 0;
    forever begin
      ok = in_ready0;
      step();
      if (ok) break;
      cyc++;
      if (cyc > 50) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_op(input logic [0:7][7:0] bv, input bit gaps);
    logic [33:0] r0, r1;
    exp_a0 = {bv[3], bv[2], bv[1], bv[0]};
    exp_b0 = {bv[7], bv[6], bv[5], bv[4]};
    exp_a1 = {bv[0], bv[1], bv[2], bv[3]};
    exp_b1 = {bv[4], bv[5], bv[6], bv[7]};
    r0 = fpa_stub(exp_a0, exp_b0, ovf_mode);
    r1 = fpa_stub(exp_a1, exp_b1, ovf_mode);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(r0[8*i +: 8]);
      q1.push_back(r1[8*(3-i) +: 8]);
    end
    q0.push_back({6'b0, r0[33], r0[32]});
    q1.push_back({6'b0, r1[33], r1[32]});
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      send_byte(bv[i]);
    end
    n_tests++;
    if (busy0 !== 1'b1 || out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL calc_cycle: busy=%b out_valid=%b in_ready=%b, required 1 0 0", busy0, out_valid0, in_ready0);
    end
    n_tests++;
    if (fpa_a0 !== exp_a0 || fpa_b0 !== exp_b0) begin
      n_fail++;
      $display("FAIL operands_lsb: a=%h b=%h, required a=%h b=%h", fpa_a0, fpa_b0, exp_a0, exp_b0);
    end
    n_tests++;
    if (fpa_a1 !== exp_a1 || fpa_b1 !== exp_b1) begin
      n_fail++;
      $display("FAIL operands_msb: a=%h b=%h, required a=%h b=%h", fpa_a1, fpa_b1, exp_a1, exp_b1);
    end
    step();
    n_tests++;
    if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: out_valid=%b/%b two edges after last byte, required 1/1", out_valid0, out_valid1);
    end
  endtask

  task automatic recv_op(input int stall_at);
    logic [7:0] e0, e1;
    int k;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      while (!out_valid0 && k < 20) begin step(); k++; end
      if (q0.size() == 0 || q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_empty: byte %0d has no expected value", i);
        break;
      end
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      if (i == stall_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        repeat (10) begin
          step();
          n_tests++;
          if (out_valid0 !== 1'b1 || out_data0 !== e0 || out_data1 !== e1 || in_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b data=%h/%h in_ready=%b, required 1 %h/%h 0",
                     out_valid0, out_data0, out_data1, in_ready0, e0, e1);
          end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      n_tests++;
      if (out_valid0 !== 1'b1 || out_data0 !== e0) begin
        n_fail++;
        $display("FAIL out_byte_lsb[%0d]: valid=%b data=%h, required 1 %h", i, out_valid0, out_data0, e0);
      end
      n_tests++;
      if (out_valid1 !== 1'b1 || out_data1 !== e1) begin
        n_fail++;
        $display("FAIL out_byte_msb[%0d]: valid=%b data=%h, required 1 %h", i, out_valid1, out_data1, e1);
      end
      step();
    end
    n_tests++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready0, out_valid0, busy0);
    end
    n_tests++;
    if (fpa_a0 !== exp_a0 || fpa_b0 !== exp_b0) begin
      n_fail++;
      $display("FAIL operand_hold: a=%h b=%h, required a=%h b=%h", fpa_a0, fpa_b0, exp_a0, exp_b0);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_in_reset: got %b, required 0", in_ready0);
    end
    step();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    n_tests++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0 || out_data0 !== 8'h00 ||
        fpa_a0 !== 32'h0 || fpa_b0 !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b busy=%b out_data=%h a=%h b=%h, required 1 0 0 00 0 0",
               in_ready0, out_valid0, busy0, out_data0, fpa_a0, fpa_b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_tests++;
    if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0 || out_data0 !== 8'h00 || fpa_a0 !== 32'h0) begin
      n_fail++;
      $display("FAIL during_reset: in_ready=%b out_valid=%b busy=%b out_data=%h a=%h, required 0 0 0 00 0",
               in_ready0, out_valid0, busy0, out_data0, fpa_a0);
    end
    pulse_reset();
  endtask

  task automatic test_basic_add();
    load_op({8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h80, 8'h3F}, 1'b0);
    recv_op(-1);
  endtask

  task automatic test_msb_first();
    load_op({8'h40, 8'h40, 8'h00, 8'h00, 8'hBF, 8'h80, 8'h00, 8'h00}, 1'b0);
    recv_op(-1);
  endtask

  task automatic test_status_flags();
    ovf_mode = 1'b1;
    load_op({8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 1'b0);
    recv_op(-1);
    ovf_mode = 1'b0;
  endtask

  task automatic test_output_stall();
    load_op({8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1}, 1'b0);
    recv_op(2);
  endtask

  task automatic test_input_gaps();
    logic [0:7][7:0] bv;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) bv[i] = 8'($urandom_range(0, 255));
      load_op(bv, 1'b0);
      recv_op(-1);
      load_op(bv, 1'b1);
      recv_op(-1);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:7][7:0] bv;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) bv[i] = 8'($urandom_range(0, 255));
      load_op(bv, 1'b0);
      recv_op(n == 3 ? 4 : -1);
    end
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h99);
    pulse_reset();
    load_op({8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h80, 8'h3F}, 1'b0);
    recv_op(-1);
  endtask

  task automatic test_reset_in_send();
    load_op({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b0);
    out_ready = 1'b0;
    step();
    pulse_reset();
    n_tests++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_send: out_valid=%b/%b, required 0/0", out_valid0, out_valid1);
    end
    load_op({8'h40, 8'h40, 8'h00, 8'h00, 8'hBF, 8'h80, 8'h00, 8'h00}, 1'b0);
    recv_op(-1);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_msb_first();
    test_status_flags();
    test_output_stall();
    test_input_gaps();
    test_back_to_back();
    test_reset_mid_load();
    test_reset_in_send();
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
